// File: rtl/operand_fwd_ctrl.sv
// Operand-forwarding select generation and load-use stall control for the 8-bit pipeline.
// Optional macro HAZARD_STATS_EN builds a saturating load-use stall counter.
module operand_fwd_ctrl #(
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_ra,
    input  logic [REG_ADDR_W-1:0] id_rb,
    input  logic                  id_uses_ra,
    input  logic                  id_uses_rb,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic [15:0]           stall_count,
    output logic [3*(REG_ADDR_W+2):0] debug_view
);

    typedef struct packed {
        logic                  wr;
        logic [REG_ADDR_W-1:0] rd;
        logic                  ld;
    } trk_t;

    typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    trk_t   ex_q, mem_q, wb_q;
    trk_t   id_entry;
    state_t state;
    logic   hz;
    logic [1:0] next_a, next_b;

    always_comb begin
        hz = id_valid & ex_q.wr & ex_q.ld &
             ((id_uses_ra & (ex_q.rd == id_ra)) | (id_uses_rb & (ex_q.rd == id_rb)));
    end

    // Flush wins over a load-use hazard; in BUBBLE ex_q is empty so hz is already low.
    assign stall = (state == RUN) & hz & ~flush;

    always_comb begin
        id_entry = '0;
        if (!stall && !flush) begin
            id_entry.wr = id_valid & id_wr_en;
            id_entry.rd = id_rd;
            id_entry.ld = id_is_load;
        end
    end

    // EX/MEM is checked first so the newest producer wins.
    always_comb begin
        next_a = SEL_RF;
        if (id_uses_ra && ex_q.wr && !ex_q.ld && ex_q.rd == id_ra)
            next_a = SEL_MEM;
        else if (id_uses_ra && mem_q.wr && mem_q.rd == id_ra)
            next_a = SEL_WB;

        next_b = SEL_RF;
        if (id_uses_rb && ex_q.wr && !ex_q.ld && ex_q.rd == id_rb)
            next_b = SEL_MEM;
        else if (id_uses_rb && mem_q.wr && mem_q.rd == id_rb)
            next_b = SEL_WB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
            state     <= RUN;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= id_entry;
            if (stall || flush) begin
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end else begin
                fwd_a_sel <= next_a;
                fwd_b_sel <= next_b;
            end
            case (state)
                RUN:     state <= (hz && !flush) ? BUBBLE : RUN;
                BUBBLE:  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (stall && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

    // wb_q never feeds the selects (write-before-read register file); it is visible here only.
    assign debug_view = {state, ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Bench for operand_fwd_ctrl: directed pipeline scenarios with literal expectations plus
// random traffic compared every cycle against a history-based model of instruction flow.
module tb_operand_fwd_ctrl;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_valid;
  logic [W-1:0] id_ra, id_rb, id_rd;
  logic         id_uses_ra, id_uses_rb, id_wr_en, id_is_load, flush;
  logic [1:0]   fwd_a_sel, fwd_b_sel;
  logic         stall;
  logic [15:0]  stall_count;
  logic [3*(W+2):0] debug_view;

  operand_fwd_ctrl #(.REG_ADDR_W(W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_wr_en(id_wr_en),
    .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .stall_count(stall_count), .debug_view(debug_view)
  );

  always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Instructions that have entered EX, oldest first; last element is in EX, the one before in MEM.
  typedef struct { bit wr; int rd; bit ld; } instr_t;
  instr_t hist[$];
  bit     started = 0;
  int     exp_a = 0, exp_b = 0, exp_cnt = 0;

  function automatic bit model_stall();
    instr_t ex;
    bit hit;
    ex = hist[hist.size()-1];
    hit = (id_uses_ra && ex.rd == int'(id_ra)) || (id_uses_rb && ex.rd == int'(id_rb));
    return id_valid && !flush && ex.wr && ex.ld && hit;
  endfunction

  function automatic int model_sel(input bit uses, input int r);
    instr_t ex, mem;
    ex  = hist[hist.size()-1];
    mem = hist[hist.size()-2];
    if (!uses) return 0;
    if (ex.wr && !ex.ld && ex.rd == r) return 1;
    if (mem.wr && mem.rd == r) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    instr_t nx, bub;
    bit s;
    bub = '{0, 0, 0};
    if (rst) begin
      hist = {bub, bub, bub};
      exp_a = 0; exp_b = 0; exp_cnt = 0;
      started = 1;
    end else if (started) begin
      s = model_stall();
      if (s || flush) begin
        exp_a = 0; exp_b = 0; nx = bub;
      end else begin
        exp_a = model_sel(id_uses_ra, int'(id_ra));
        exp_b = model_sel(id_uses_rb, int'(id_rb));
        nx = '{id_valid && id_wr_en, int'(id_rd), id_is_load};
      end
      hist.push_back(nx);
      void'(hist.pop_front());
      if (STATS && s && exp_cnt != 16'hFFFF) exp_cnt++;
    end
  end

  // Compare process: outputs sampled mid-cycle against the model.
  always @(negedge clk) begin
    if (started) begin
      check("stall", int'(stall), int'(model_stall()));
      check("fwd_a_sel", int'(fwd_a_sel), exp_a);
      check("fwd_b_sel", int'(fwd_b_sel), exp_b);
      check("stall_count", int'(stall_count), exp_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int ra, input bit ua, input int rb, input bit ub,
                        input bit wr, input int rd, input bit ld, input bit fl);
    id_valid = v; id_ra = W'(ra); id_uses_ra = ua; id_rb = W'(rb); id_uses_rb = ub;
    id_wr_en = wr; id_rd = W'(rd); id_is_load = ld; flush = fl;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int cnt0;

  initial begin
    rst = 1'b1;
    set_id(1, 1, 1, 1, 1, 1, 1, 0, 0);
    tick(); tick();
    check("reset_a", int'(fwd_a_sel), 0);
    check("reset_b", int'(fwd_b_sel), 0);
    check("reset_stall", int'(stall), 0);
    check("reset_count", int'(stall_count), 0);
    rst = 1'b0;
    nop(); tick(); tick();

    // ADD r1 ; SUB r2,r1,r3
    set_id(1, 0, 1, 0, 1, 1, 1, 0, 0); tick();
    set_id(1, 1, 1, 3, 1, 1, 2, 0, 0); #1 check("exmem_nostall", int'(stall), 0); tick();
    check("exmem_a", int'(fwd_a_sel), 1);
    check("exmem_b", int'(fwd_b_sel), 0);
    nop(); tick(); tick();

    // ADD r1 ; NOP ; OR r0,r1
    set_id(1, 2, 1, 3, 1, 1, 1, 0, 0); tick();
    nop(); tick();
    set_id(1, 0, 1, 1, 1, 1, 0, 0, 0); tick();
    check("memwb_b", int'(fwd_b_sel), 2);
    check("memwb_a", int'(fwd_a_sel), 0);
    nop(); tick(); tick();

    // ADD r1 ; ADD r1 ; AND r2,r1
    set_id(1, 0, 1, 0, 1, 1, 1, 0, 0); tick();
    set_id(1, 0, 1, 0, 1, 1, 1, 0, 0); tick();
    set_id(1, 1, 1, 2, 1, 1, 2, 0, 0); tick();
    check("priority_a", int'(fwd_a_sel), 1);
    nop(); tick(); tick();

    // LD r2 ; ADD r0,r2
    cnt0 = int'(stall_count);
    set_id(1, 0, 1, 0, 0, 1, 2, 1, 0); tick();
    set_id(1, 0, 1, 2, 1, 1, 0, 0, 0); #1 check("lu_stall", int'(stall), 1); tick();
    check("lu_bubble_a", int'(fwd_a_sel), 0);
    check("lu_bubble_b", int'(fwd_b_sel), 0);
    check("lu_stall_once", int'(stall), 0);
    tick();
    check("lu_fwd_b", int'(fwd_b_sel), 2);
    check("lu_count", int'(stall_count), STATS ? cnt0 + 1 : 0);
    nop(); tick(); tick();

    // LD r2 in EX, consumer in ID with flush
    cnt0 = int'(stall_count);
    set_id(1, 0, 1, 0, 0, 1, 2, 1, 0); tick();
    set_id(1, 2, 1, 0, 0, 1, 0, 0, 1); #1 check("flush_stall", int'(stall), 0); tick();
    check("flush_a", int'(fwd_a_sel), 0);
    check("flush_count", int'(stall_count), cnt0);
    set_id(1, 2, 1, 0, 0, 1, 0, 0, 0); #1 check("flush_ex_bubble", int'(stall), 0); tick();
    nop(); tick(); tick();

    // Random traffic with occasional reset and flush.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;

`ifdef HAZARD_STATS_EN
    // Self-dependent load held in ID stalls every other cycle.
    set_id(1, 2, 1, 0, 0, 1, 2, 1, 0);
    for (int i = 0; i < 2 * 65540 + 4; i++) tick();
    check("saturate", int'(stall_count), 16'hFFFF);
`endif

    nop(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
